key_matrix_emu: RTL and testbench

Emulates a passive 4x4 matrix keypad for simulation and hardware-in-the-loop testing of the keypad scanner. A requester hands over a 4-bit key code through a valid/ready handshake. The block then "presses" that key for a programmed time, with optional contact bounce, and releases it. While the key is closed, the row lines follow the scanner's column strobes exactly as a physical switch would. The block sits on the keypad pins in place of the real keypad, driven by a UART command decoder or a testbench.

---
 rtl/key_emu_pkg.sv | 23 ++
 rtl/ms_tick_gen.sv | 27 ++
 rtl/key_matrix_emu.sv | 155 +++++++++++++++
 tb/tb_key_matrix_emu.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/key_emu_pkg.sv
// Shared types and helpers for the keypad matrix emulator.
package key_emu_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    BOUNCE_IN  = 3'd1,
    HOLD       = 3'd2,
    BOUNCE_OUT = 3'd3,
    GAP        = 3'd4
  } state_t;

  localparam logic [3:0] IDLE_ROW = 4'b1111;

  // Clock cycles per millisecond, never less than one.
  function automatic int cycles_per_ms(input int clk_hz);
    return (clk_hz / 1000 < 1) ? 1 : clk_hz / 1000;
  endfunction

  function automatic int at_least_one(input int v);
    return (v < 1) ? 1 : v;
  endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// Clearable prescaler: one-cycle tick every CYCLES clocks, restarted by clear.
module ms_tick_gen #(
  parameter int CYCLES = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic tick
);

  localparam int CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;

  logic [CW-1:0] count;

  assign tick = (count == CW'(CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear || tick) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/key_matrix_emu.sv
// 4x4 passive keypad emulator: timed key press with optional contact bounce.
// Bounce phases are built only when KEY_EMU_BOUNCE_EN is defined.
module key_matrix_emu
  import key_emu_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int PRESS_MS   = 50,
  parameter int RELEASE_MS = 30,
  parameter int BOUNCE_MS  = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] col,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  output logic       key_ready,
  output logic [3:0] row,
  output logic       busy,
  output logic       done
);

  localparam int CYC       = cycles_per_ms(CLK_HZ);
  localparam int PRESS_L   = at_least_one(PRESS_MS);
  localparam int RELEASE_L = at_least_one(RELEASE_MS);
  localparam int BOUNCE_L  = at_least_one(BOUNCE_MS);
  localparam int MAX_PR    = (PRESS_L > RELEASE_L) ? PRESS_L : RELEASE_L;
  localparam int MAX_MS    = (MAX_PR > BOUNCE_L) ? MAX_PR : BOUNCE_L;
  localparam int MS_W      = (MAX_MS > 1) ? $clog2(MAX_MS) : 1;

  state_t          state;
  logic [3:0]      code;
  logic [MS_W-1:0] ms_cnt;
  logic [MS_W-1:0] phase_last;
  logic            accept;
  logic            ms_tick;
  logic            phase_end;
  logic            contact;

  assign accept    = key_valid && key_ready;
  assign phase_end = ms_tick && (ms_cnt == phase_last);

  // Prescaler restarts on accept so every phase is a whole number of ms.
  ms_tick_gen #(
    .CYCLES(CYC)
  ) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .clear(accept),
    .tick (ms_tick)
  );

  always_comb begin
    phase_last = '0;
    case (state)
      BOUNCE_IN, BOUNCE_OUT: phase_last = MS_W'(BOUNCE_L - 1);
      HOLD:                  phase_last = MS_W'(PRESS_L - 1);
      GAP:                   phase_last = MS_W'(RELEASE_L - 1);
      default:               phase_last = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      code      <= '0;
      ms_cnt    <= '0;
      key_ready <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            code      <= key_code;
            ms_cnt    <= '0;
            key_ready <= 1'b0;
            busy      <= 1'b1;
`ifdef KEY_EMU_BOUNCE_EN
            state     <= BOUNCE_IN;
`else
            state     <= HOLD;
`endif
          end
        end
`ifdef KEY_EMU_BOUNCE_EN
        BOUNCE_IN: begin
          if (phase_end) begin
            ms_cnt <= '0;
            state  <= HOLD;
          end else if (ms_tick) begin
            ms_cnt <= ms_cnt + MS_W'(1);
          end
        end
        BOUNCE_OUT: begin
          if (phase_end) begin
            ms_cnt <= '0;
            state  <= GAP;
          end else if (ms_tick) begin
            ms_cnt <= ms_cnt + MS_W'(1);
          end
        end
`endif
        HOLD: begin
          if (phase_end) begin
            ms_cnt <= '0;
`ifdef KEY_EMU_BOUNCE_EN
            state  <= BOUNCE_OUT;
`else
            state  <= GAP;
`endif
          end else if (ms_tick) begin
            ms_cnt <= ms_cnt + MS_W'(1);
          end
        end
        GAP: begin
          if (phase_end) begin
            ms_cnt    <= '0;
            state     <= IDLE;
            done      <= 1'b1;
            key_ready <= 1'b1;
            busy      <= 1'b0;
          end else if (ms_tick) begin
            ms_cnt <= ms_cnt + MS_W'(1);
          end
        end
        default: begin
          state     <= IDLE;
          ms_cnt    <= '0;
          key_ready <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
    end
  end

  // Bounce: entering edge is closed on even ms, leaving edge closed on odd ms.
  always_comb begin
    contact = 1'b0;
    case (state)
      BOUNCE_IN:  contact = ~ms_cnt[0];
      HOLD:       contact = 1'b1;
      BOUNCE_OUT: contact = ms_cnt[0];
      default:    contact = 1'b0;
    endcase
  end

  always_comb begin
    row = IDLE_ROW;
    if (contact) begin
      row[code[3:2]] = col[code[1:0]];
    end
  end

endmodule

// File: tb/tb_key_matrix_emu.sv
// Scoreboard bench for key_matrix_emu: accepts queue expected presses, a monitor checks row/status per cycle.
module tb_key_matrix_emu;

  localparam int CYC = 4;
  localparam int P   = 6;
  localparam int R   = 3;
  localparam int B   = 2;
`ifdef KEY_EMU_BOUNCE_EN
  localparam int TOTAL = (2 * B + P + R) * CYC;
`else
  localparam int TOTAL = (P + R) * CYC;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] col;
  logic       key_valid;
  logic [3:0] key_code;
  logic       key_ready;
  logic [3:0] row;
  logic       busy;
  logic       done;

  key_matrix_emu #(
    .CLK_HZ    (CYC * 1000),
    .PRESS_MS  (P),
    .RELEASE_MS(R),
    .BOUNCE_MS (B)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .col      (col),
    .key_valid(key_valid),
    .key_code (key_code),
    .key_ready(key_ready),
    .row      (row),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] code;
    int         start;
  } txn_t;

  txn_t exp_q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;
  bit   rand_col = 1'b1;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference press profile, expressed in whole milliseconds since accept.
  function automatic logic [3:0] exp_row(input logic [3:0] code, input logic [3:0] c, input int t);
    int ms;
    bit closed;
    logic [3:0] r;
    ms = t / CYC;
`ifdef KEY_EMU_BOUNCE_EN
    if (ms < B)              closed = (ms % 2 == 0);
    else if (ms < B + P)     closed = 1'b1;
    else if (ms < 2 * B + P) closed = ((ms - B - P) % 2 == 1);
    else                     closed = 1'b0;
`else
    closed = (ms < P);
`endif
    r = 4'b1111;
    if (closed) r[code / 4] = c[code % 4];
    return r;
  endfunction

  // Producer: every handshake seen issues an expected press starting next edge.
  always @(negedge clk) begin
    if (mon_en && rst_n && key_valid && key_ready) begin
      exp_q.push_back('{code: key_code, start: cyc + 1});
    end
  end

  int         row_err = 0;
  int         st_err = 0;
  int         idle_err = 0;
  int         first_t = -1;
  logic [3:0] first_got, first_exp;

  always @(negedge clk) begin
    int t;
    logic [3:0] er;
    if (mon_en) begin
      if (exp_q.size() > 0 && cyc >= exp_q[0].start) begin
        t = cyc - exp_q[0].start;
        if (t < TOTAL) begin
          er = exp_row(exp_q[0].code, col, t);
          if (row !== er) begin
            if (row_err == 0) begin
              first_t = t; first_got = row; first_exp = er;
            end
            row_err++;
          end
          if (busy !== 1'b1 || key_ready !== 1'b0 || done !== 1'b0) st_err++;
        end else begin
          chk("done_edge", {28'd0, done, key_ready, busy, 1'b0}, {28'd0, 4'b1100});
          chk("row_after", {28'd0, row}, 32'hF);
          if (row_err != 0)
            $display("FAIL row_trace: %0d bad cycles, first t=%0d got %b expected %b",
                     row_err, first_t, first_got, first_exp);
          checks++;
          if (row_err != 0) errors++;
          chk("status_trace", st_err, 0);
          $display("txn code=%0d start=%0d row_err=%0d status_err=%0d",
                   exp_q[0].code, exp_q[0].start, row_err, st_err);
          row_err = 0;
          st_err  = 0;
          void'(exp_q.pop_front());
        end
      end else begin
        if (row !== 4'hF || busy !== 1'b0 || done !== 1'b0 || key_ready !== 1'b1) idle_err++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (rand_col) col = 4'($urandom);
  endtask

  task automatic wait_idle(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (!busy && key_ready) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    chk(name, {31'd0, ok}, 32'd1);
  endtask

  task automatic send(input logic [3:0] code);
    wait_idle("ready_wait");
    key_valid = 1'b1;
    key_code  = code;
    step();
    key_valid = 1'b0;
  endtask

  initial begin
    int dn;
    rst_n = 1'b0; key_valid = 1'b0; key_code = 4'd0; col = 4'b0000;
    repeat (2) @(negedge clk);
    chk("rst_row", {28'd0, row}, 32'hF);
    chk("rst_ready", {31'd0, key_ready}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    mon_en = 1'b1;
    step();

    // Code 5 with col toggling between selected column low and other column low.
    rand_col = 1'b0; col = 4'b1101;
    send(4'd5);
    for (int i = 0; i < 100 && busy; i++) begin
      col = i[0] ? 4'b1110 : 4'b1101;
      step();
    end
    wait_idle("idle_c5");

    // Code 15 with all columns strobed.
    col = 4'b0000;
    send(4'd15);
    wait_idle("idle_c15");

    // Request for code 3 while code 9 is held must be ignored.
    rand_col = 1'b1;
    send(4'd9);
    repeat (9) step();
    key_valid = 1'b1; key_code = 4'd3;
    repeat (4) step();
    key_valid = 1'b0;
    wait_idle("idle_c9");

    // Reset mid-hold: immediate release, no done pulse, ready afterwards.
    rand_col = 1'b0; col = 4'b0000;
    send(4'd6);
    repeat (11) step();
    chk("pre_rst_busy", {31'd0, busy}, 32'd1);
    mon_en = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("async_rst_row", {28'd0, row}, 32'hF);
    chk("async_rst_busy", {31'd0, busy}, 32'd0);
    dn = 0;
    repeat (3) begin
      @(negedge clk);
      if (done !== 1'b0) dn++;
    end
    chk("rst_no_done", dn, 0);
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", {31'd0, key_ready}, 32'd1);
    mon_en = 1'b1;
    step();

    // Back-to-back: valid held, second accept right after done.
    rand_col = 1'b1;
    key_valid = 1'b1; key_code = 4'd0;
    step();
    chk("b2b_first", {31'd0, busy}, 32'd1);
    key_code = 4'd12;
    dn = 0;
    for (int i = 0; i < 200 && !done; i++) step();
    chk("b2b_done", {31'd0, done}, 32'd1);
    step();
    chk("b2b_second", {31'd0, busy}, 32'd1);
    key_valid = 1'b0;
    wait_idle("idle_b2b");

    // Randomized presses with random idle spacing.
    for (int n = 0; n < 6; n++) begin
      repeat ($urandom_range(0, 3)) step();
      send(4'($urandom));
    end
    wait_idle("idle_rand");
    repeat (3) step();

    chk("drain", exp_q.size(), 0);
    chk("idle_trace", idle_err, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
